// File: rtl/pri_enc_arb.sv
// Registered priority encoder / arbiter with fixed-priority and round-robin modes.
// One grant is presented at a time on a valid/ready output stage.
module pri_enc_arb #(
  parameter int unsigned N = 8,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         busy_any
);

  logic         out_valid_q;
  logic [W-1:0] out_idx_q;
  logic [N-1:0] out_onehot_q;
  logic [W-1:0] ptr_q, ptr_d;

  logic         load;
  logic         accept;
  logic [N-1:0] le_mask;
  logic [N-1:0] masked;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_oh;

  // Index of the highest set bit; zero when the vector is empty.
  function automatic logic [W-1:0] hi_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  assign busy_any = |req;

  always_comb begin
    accept = out_valid_q && out_ready;
    load   = !out_valid_q || out_ready;

    // Pointer advances past the grant being accepted, and the same edge already
    // searches from the advanced pointer so back-to-back grants rotate correctly.
    ptr_d = ptr_q;
    if (accept && mode) begin
      ptr_d = (out_idx_q == '0) ? W'(N - 1) : out_idx_q - W'(1);
    end

    // Descending search from ptr with wrap == highest bit at or below ptr,
    // falling back to the highest bit overall when nothing lies at or below it.
    for (int unsigned i = 0; i < N; i++) begin
      le_mask[i] = (W'(i) <= ptr_d);
    end
    masked = req & le_mask;

    if (mode && (|masked)) begin
      win_idx = hi_idx(masked);
    end else begin
      win_idx = hi_idx(req);
    end

    for (int unsigned i = 0; i < N; i++) begin
      win_oh[i] = (win_idx == W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      ptr_q        <= W'(N - 1);
    end else begin
      if (load) begin
        if (|req) begin
          out_valid_q  <= 1'b1;
          out_idx_q    <= win_idx;
          out_onehot_q <= win_oh;
        end else begin
          out_valid_q  <= 1'b0;
          out_idx_q    <= '0;
          out_onehot_q <= '0;
        end
      end
      ptr_q <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_pri_enc_arb.sv
// Directed and model-checked bench for pri_enc_arb at N = 8.
module tb_pri_enc_arb;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         busy_any;

  int checks = 0;
  int errors = 0;

  pri_enc_arb #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .busy_any   (busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic v, input int idx);
    logic [N-1:0] oh;
    oh = v ? (N'(1) << idx) : '0;
    check({tag, " valid"}, 64'(out_valid), 64'(v));
    check({tag, " idx"}, 64'(out_idx), v ? 64'(idx) : 64'd0);
    check({tag, " onehot"}, 64'(out_onehot), 64'(oh));
  endtask

  // Reference model state: search is a literal descending walk with wrap.
  logic       m_valid;
  int         m_idx;
  int         m_ptr;

  task automatic model_edge(input logic r_n, input logic [N-1:0] r, input logic md,
                            input logic rdy);
    bit ld, hs, found;
    int p, j;
    if (!r_n) begin
      m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;
      return;
    end
    ld = !m_valid || rdy;
    hs = m_valid && rdy;
    p  = (hs && md) ? ((m_idx == 0) ? N - 1 : m_idx - 1) : m_ptr;
    if (ld) begin
      if (r == '0) begin
        m_valid = 1'b0; m_idx = 0;
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          j = md ? ((p - k + N) % N) : (N - 1 - k);
          if (!found && r[j]) begin
            m_idx = j; found = 1;
          end
        end
        m_valid = 1'b1;
      end
    end
    m_ptr = p;
  endtask

  initial begin
    int rr_exp[6];
    int ms_exp[6];
    logic ms_mode[6];
    rr_exp = '{7, 3, 0, 7, 3, 0};
    ms_exp = '{7, 0, 7, 7, 0, 7};
    ms_mode = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset with all requests pending.
    rst_n = 1'b0; req = 8'hFF; mode = 1'b0; out_ready = 1'b1;
    step(); step();
    expect_grant("reset", 1'b0, 0);
    check("busy_any ff", 64'(busy_any), 64'd1);
    rst_n = 1'b1;
    step();
    expect_grant("post reset", 1'b1, 7);

    // Fixed priority.
    req = 8'b0010_0110; step();
    expect_grant("fixed 26", 1'b1, 5);
    req = 8'h01; step();
    expect_grant("fixed 01", 1'b1, 0);
    req = 8'h00; #1;
    check("busy_any 0", 64'(busy_any), 64'd0);
    step();
    expect_grant("fixed empty", 1'b0, 0);

    // Round-robin rotation, one grant per cycle.
    mode = 1'b1; req = 8'b1000_1001;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_grant($sformatf("rr %0d", i), 1'b1, rr_exp[i]);
    end

    // Stall: grant 4 held while req changes.
    mode = 1'b0; req = 8'h10; step();
    expect_grant("stall load", 1'b1, 4);
    out_ready = 1'b0; req = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_grant($sformatf("stall %0d", i), 1'b1, 4);
    end
    out_ready = 1'b1; step();
    expect_grant("stall release", 1'b1, 7);

    // Reset mid-stall discards the held grant.
    out_ready = 1'b0; step();
    rst_n = 1'b0; step();
    expect_grant("reset in stall", 1'b0, 0);
    rst_n = 1'b1; out_ready = 1'b1;

    // Mode switch with retained pointer (ptr is N-1 after reset).
    req = 8'h81;
    for (int i = 0; i < 6; i++) begin
      mode = ms_mode[i];
      step();
      expect_grant($sformatf("mode sw %0d", i), 1'b1, ms_exp[i]);
    end

    // Random run against the reference model.
    rst_n = 1'b0; step();
    model_edge(1'b0, req, mode, out_ready);
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      req       = N'($urandom) & N'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      model_edge(rst_n, req, mode, out_ready);
      step();
      expect_grant($sformatf("rand %0d", i), m_valid, m_idx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_enc_arb.md
# pri_enc_arb

Parametrised, registered priority encoder/arbiter: scans an N-bit request vector, selects one winner by fixed priority (highest index wins) or round-robin, and presents its binary index and one-hot grant on a valid/ready output stage. Next generation of the combinational 8:3 priority encoder; it sits between request sources (interrupt lines, channel requests) and a single downstream consumer that accepts one grant at a time.

## Interface
- N, default 8, number of request lines; legal range 2..64.
- W, default $clog2(N), index width; derived, not overridden.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  N  request vector, level-sensitive; bit k = request from source k.
- mode  input  1  0 = fixed priority, 1 = round-robin.
- out_ready  input  1  consumer accepts current grant when high with out_valid.
- out_valid  output  1  registered; a grant is held on out_idx/out_onehot.
- out_idx  output  W  registered binary index of winning request.
- out_onehot  output  N  registered one-hot grant; equals 1 << out_idx when out_valid, else 0.
- busy_any  output  1  combinational OR of req (no register).

## Operation
- Load condition: load = !out_valid || out_ready. Output register updates only on load; otherwise all outputs hold.
- On load with req == 0: out_valid <= 0, out_idx <= 0, out_onehot <= 0.
- On load with req != 0: out_valid <= 1, out_idx/out_onehot <= winner.
- Fixed priority (mode=0): winner = highest set index (bit N-1 highest, bit 0 lowest) — same ordering as the 8:3 encoder.
- Round-robin (mode=1): search starts at index ptr and descends, wrapping from 0 to N-1; first set bit wins.
- Pointer ptr (W bits, internal): reset to N-1 (round-robin initially identical to fixed). Updates only on a handshake (out_valid && out_ready) in mode=1: ptr <= (g == 0) ? N-1 : g-1, where g = out_idx being accepted. In mode=0 ptr holds.
- Handshake completes when out_valid && out_ready in the same cycle; the same edge loads the next winner (back-to-back grants, no bubble).
- req is sampled only at load; changes while a grant is stalled do not alter out_idx (the held grant may name a request since dropped; consumer tolerates this).
- mode is sampled at load; a mode change mid-stall affects the next load only.
- Simultaneous handshake and mode change: ptr update uses mode value in that cycle.
- Never output X or Z: empty request gives out_valid=0, replacing the old 3'bzzz behaviour.

## Timing
- Reset (rst_n=0 at a rising edge): out_valid=0, out_idx=0, out_onehot=0, ptr=N-1, regardless of req/out_ready. Reset mid-stall discards the held grant.
- Latency: req change to out_valid/out_idx = 1 cycle when the stage is empty or being accepted.
- Throughput: one grant per cycle with out_ready held high.
- Stall: out_valid, out_idx, out_onehot stable while out_valid && !out_ready.
- busy_any: zero-cycle, combinational from req.
- Critical path: N-bit rotate + priority scan; single cycle at N=64 target.

## Test plan
- Reset: rst_n=0 two cycles with req=8'hFF, out_ready=1 -> out_valid=0, out_idx=0, out_onehot=0; first edge after release -> out_valid=1, out_idx=7.
- Fixed priority sweep (N=8, mode=0, out_ready=1): req=8'b0010_0110 -> out_idx=5, out_onehot=8'h20 one cycle later; req=8'h01 -> out_idx=0; req=0 -> out_valid=0.
- Round-robin rotation (mode=1, req=8'b1000_1001 constant, out_ready=1): grants 7,3,0,7,3,... one per cycle, no bubbles.
- Stall/hold: grant idx=4 valid, out_ready=0 for 5 cycles while req changes to 8'h80 -> out_idx stays 4; out_ready=1 -> next cycle out_idx=7.
- Mode switch: after RR grant of 7 (ptr=6) with req=8'h81, switch mode=0 -> next grant 7 (fixed), not 0; switch back mode=1 -> grant 0 per retained ptr... then 7.
- Width generalisation: N=5 and N=64 random req/out_ready/mode for 10k cycles vs. reference model; check out_onehot == 1<<out_idx and stability under stall.
